// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle control sequencer.
// Holds the FSM state encoding, the opcode map and the encodings of every
// datapath select field (AluOp, SrcA, SrcB, register sources, pc_src).
// The helper functions classify opcodes for the decoder.
package cpu_defs;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcodes, ir[15:12]
  localparam logic [3:0] OP_AADD  = 4'h0;
  localparam logic [3:0] OP_AADDM = 4'h1;
  localparam logic [3:0] OP_ASUB  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_MOVS  = 4'h5;
  localparam logic [3:0] OP_COMP  = 4'h6;
  localparam logic [3:0] OP_BEQZ  = 4'h7;
  localparam logic [3:0] OP_JAL   = 4'h8;
  localparam logic [3:0] OP_RET   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU operations
  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_SLL   = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // ALU operand selects
  localparam logic       SRCA_MARY    = 1'b0;
  localparam logic       SRCA_PC      = 1'b1;
  localparam logic [1:0] SRCB_MEM     = 2'b00;
  localparam logic [1:0] SRCB_IMM     = 2'b01;
  localparam logic [1:0] SRCB_SHELLEY = 2'b10;
  localparam logic [1:0] SRCB_ONE     = 2'b11;

  // Register write-data selects
  localparam logic [1:0] MARY_ALU     = 2'b00;
  localparam logic [1:0] MARY_MEM     = 2'b01;
  localparam logic [1:0] MARY_SHELLEY = 2'b10;
  localparam logic [1:0] SHELLEY_MARY = 2'b00;
  localparam logic [1:0] SHELLEY_ALU  = 2'b01;
  localparam logic [1:0] SHELLEY_MEM  = 2'b10;
  localparam logic       RA_PC1       = 1'b0;
  localparam logic       RA_ALU       = 1'b1;

  // Next-PC selects
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_IMM = 2'b10;
  localparam logic [1:0] PC_RA  = 2'b11;

  // Opcodes that need a data memory access before EXEC
  function automatic logic needs_mem(input logic [3:0] op);
    return (op == OP_AADDM) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Opcodes 0xA..0xE have no defined meaning
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  // Arithmetic opcodes whose ALU overflow is reported
  function automatic logic sets_ovf(input logic [3:0] op);
    return (op == OP_AADD) || (op == OP_AADDM) || (op == OP_ASUB) || (op == OP_COMP);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Handshake watchdog for the memory request.
// Ports: clock/reset_n (async active-low), clear (zero the count),
// count_en (one more wait cycle), at_limit (the current wait cycle is the
// LIMIT-th one; the caller decides whether it is a timeout).
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic at_limit
);

  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] count;

  // Wait-cycle counter: cleared outside memory accesses, advances per stalled cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

  // LIMIT-1 waits already seen, so a further stall is the LIMIT-th
  assign at_limit = (count == LIMIT_M1);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle controller for the mary/shelley/comp/ra register block and ALU.
// Fetches 16-bit instructions over a req/ready handshake, decodes
// opcode ir[15:12] and immediate ir[7:0], and sequences
// FETCH -> DECODE -> [MEM] -> EXEC -> FETCH, with HALT terminal until reset.
// Ports: clock, reset_n (async active-low); mem_rdata/mem_ready from memory;
// comp_zero/overflow from the datapath; mem_req/mem_we/mem_addr_sel to memory;
// immediate, write strobes, source selects, SrcA/SrcB/AluOp, pc_write/pc_src
// to the datapath; halted/illegal/bus_error/ovf_flag sticky status.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        comp_zero,
  input  logic        overflow,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [7:0]  immediate,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        comp_write,
  output logic        ra_write,
  output logic [1:0]  mary_src,
  output logic [1:0]  shelley_src,
  output logic        ra_src,
  output logic        SrcA,
  output logic [1:0]  SrcB,
  output logic [2:0]  AluOp,
  output logic        halted,
  output logic        illegal,
  output logic        bus_error,
  output logic        ovf_flag
);

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic        req;
  logic        in_access;
  logic        at_limit;
  logic        timeout;
  logic        unused_ir;

  assign opcode    = ir[15:12];
  assign immediate = ir[7:0];
  assign unused_ir = ^ir[11:8];

  assign in_access = (state == ST_FETCH) || (state == ST_MEM);
  // A ready in the limit cycle completes the access instead of timing out
  assign timeout   = in_access && !mem_ready && at_limit;

  // Request is cut the moment reset asserts, even mid-access
  assign mem_req = req & reset_n;

  wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (!in_access),
    .count_en (in_access && !mem_ready),
    .at_limit (at_limit)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register, loaded on a completed fetch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir <= 16'h0000;
    end else if ((state == ST_FETCH) && mem_ready) begin
      ir <= mem_rdata;
    end
  end

  // Sticky status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted    <= 1'b0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if (state_next == ST_HALT) halted <= 1'b1;
      if ((state == ST_DECODE) && is_illegal(opcode)) illegal <= 1'b1;
      if (timeout) bus_error <= 1'b1;
      if ((state == ST_EXEC) && sets_ovf(opcode) && overflow) ovf_flag <= 1'b1;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next    = state;
    req           = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_INC;
    mary_write    = 1'b0;
    shelley_write = 1'b0;
    comp_write    = 1'b0;
    ra_write      = 1'b0;
    mary_src      = MARY_ALU;
    shelley_src   = SHELLEY_MARY;
    ra_src        = RA_PC1;
    SrcA          = SRCA_MARY;
    SrcB          = SRCB_MEM;
    AluOp         = ALU_AND;
    case (state)
      ST_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HALT) begin
          state_next = ST_HALT;
        end else if (is_illegal(opcode)) begin
          state_next = ST_HALT;
        end else if (needs_mem(opcode)) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_MEM: begin
        req          = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          state_next = ST_EXEC;
        end else if (timeout) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_MEM;
        end
      end
      ST_EXEC: begin
        pc_write   = 1'b1;
        state_next = ST_FETCH;
        case (opcode)
          OP_AADD: begin
            mary_write = 1'b1;
            SrcB       = SRCB_IMM;
            AluOp      = ALU_ADD;
          end
          OP_AADDM: begin
            shelley_write = 1'b1;
            SrcB          = SRCB_MEM;
            AluOp         = ALU_ADD;
            shelley_src   = SHELLEY_ALU;
          end
          OP_ASUB: begin
            mary_write = 1'b1;
            SrcB       = SRCB_IMM;
            AluOp      = ALU_SUB;
          end
          OP_LOAD: begin
            mary_write = 1'b1;
            mary_src   = MARY_MEM;
          end
          OP_MOVS: begin
            shelley_write = 1'b1;
          end
          OP_COMP: begin
            comp_write = 1'b1;
            SrcB       = SRCB_SHELLEY;
            AluOp      = ALU_SUB;
          end
          OP_BEQZ: begin
            pc_src = comp_zero ? PC_REL : PC_INC;
          end
          OP_JAL: begin
            ra_write = 1'b1;
            pc_src   = PC_IMM;
          end
          OP_RET: begin
            pc_src = PC_RA;
          end
          default: begin
            // STORE: data path already presented mary during MEM
            pc_src = PC_INC;
          end
        endcase
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock;
  logic        reset_n;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        comp_zero;
  logic        overflow;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [7:0]  immediate;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        mary_write, shelley_write, comp_write, ra_write;
  logic [1:0]  mary_src, shelley_src;
  logic        ra_src, SrcA;
  logic [1:0]  SrcB;
  logic [2:0]  AluOp;
  logic        halted, illegal, bus_error, ovf_flag;

  typedef struct packed {
    logic       req, we, asel, pcw;
    logic [1:0] pcs;
    logic       mw, sw, cw, rw;
    logic [1:0] ms, ss;
    logic       rs, sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic       hlt, ill, berr, ovf;
    logic [7:0] imm;
  } ctl_t;

  typedef struct {
    string       name;
    logic [15:0] rdata;
    logic        ready;
    logic        cz;
    logic        ov;
    ctl_t        exp;
  } vec_t;

  vec_t vecs[$];
  ctl_t act;
  ctl_t e;
  int   total = 0;
  int   bad   = 0;

  control_sequencer #(.WAIT_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .comp_zero(comp_zero), .overflow(overflow), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .immediate(immediate), .pc_write(pc_write), .pc_src(pc_src),
    .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
    .ra_write(ra_write), .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src),
    .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp), .halted(halted), .illegal(illegal),
    .bus_error(bus_error), .ovf_flag(ovf_flag)
  );

  assign act = {mem_req, mem_we, mem_addr_sel, pc_write, pc_src, mary_write, shelley_write,
                comp_write, ra_write, mary_src, shelley_src, ra_src, SrcA, SrcB, AluOp,
                halted, illegal, bus_error, ovf_flag, immediate};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t cf(input logic [7:0] imm);
    ctl_t c = '0;
    c.req = 1'b1;
    c.imm = imm;
    return c;
  endfunction

  function automatic ctl_t cd(input logic [7:0] imm);
    ctl_t c = '0;
    c.imm = imm;
    return c;
  endfunction

  function automatic ctl_t cm(input logic [7:0] imm, input logic we);
    ctl_t c = '0;
    c.req  = 1'b1;
    c.asel = 1'b1;
    c.we   = we;
    c.imm  = imm;
    return c;
  endfunction

  function automatic ctl_t cx(input logic [7:0] imm);
    ctl_t c = '0;
    c.pcw = 1'b1;
    c.imm = imm;
    return c;
  endfunction

  function automatic void add(input string n, input logic [15:0] rd, input logic rdy,
                              input logic cz, input logic ov, input ctl_t x);
    vec_t v;
    v.name = n; v.rdata = rd; v.ready = rdy; v.cz = cz; v.ov = ov; v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input ctl_t x);
    total++;
    if (act !== x) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, x);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare, move to next falling edge
  task automatic step(input string name, input logic [15:0] rd, input logic rdy,
                      input logic cz, input logic ov, input ctl_t x);
    mem_rdata = rd; mem_ready = rdy; comp_zero = cz; overflow = ov;
    #1;
    check(name, x);
    @(negedge clock);
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check(name, '0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; mem_rdata = 16'hFFFF; mem_ready = 1'b1; comp_zero = 1'b1; overflow = 1'b1;

    // AADD imm=84, ready at once
    add("aadd_f", 16'h0054, 1'b1, 1'b0, 1'b0, cf(8'h00));
    add("aadd_d", 16'h0000, 1'b0, 1'b0, 1'b1, cd(8'h54));
    e = cx(8'h54); e.mw = 1'b1; e.sb = 2'b01; e.op = 3'b010;
    add("aadd_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // AADDM imm=0x10, three waits then ready on the limit cycle
    add("aaddm_f", 16'h1010, 1'b1, 1'b0, 1'b0, cf(8'h54));
    add("aaddm_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h10));
    for (int i = 0; i < 3; i++) add("aaddm_wait", 16'h0000, 1'b0, 1'b0, 1'b0, cm(8'h10, 1'b0));
    add("aaddm_m", 16'h1234, 1'b1, 1'b0, 1'b0, cm(8'h10, 1'b0));
    e = cx(8'h10); e.sw = 1'b1; e.ss = 2'b01; e.sb = 2'b00; e.op = 3'b010;
    add("aaddm_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // BEQZ taken, then not taken
    add("beqz1_f", 16'h70FE, 1'b1, 1'b0, 1'b0, cf(8'h10));
    add("beqz1_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'hFE));
    e = cx(8'hFE); e.pcs = 2'b01;
    add("beqz1_x", 16'h0000, 1'b0, 1'b1, 1'b0, e);
    add("beqz0_f", 16'h70FE, 1'b1, 1'b0, 1'b0, cf(8'hFE));
    add("beqz0_d", 16'h0000, 1'b0, 1'b1, 1'b0, cd(8'hFE));
    add("beqz0_x", 16'h0000, 1'b0, 1'b0, 1'b0, cx(8'hFE));
    // STORE
    add("store_f", 16'h4020, 1'b1, 1'b0, 1'b0, cf(8'hFE));
    add("store_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h20));
    add("store_m", 16'h0000, 1'b1, 1'b0, 1'b0, cm(8'h20, 1'b1));
    add("store_x", 16'h0000, 1'b0, 1'b0, 1'b0, cx(8'h20));
    // COMP
    add("comp_f", 16'h6000, 1'b1, 1'b0, 1'b0, cf(8'h20));
    add("comp_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h00));
    e = cx(8'h00); e.cw = 1'b1; e.sb = 2'b10; e.op = 3'b011;
    add("comp_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // JAL
    add("jal_f", 16'h8033, 1'b1, 1'b0, 1'b0, cf(8'h00));
    add("jal_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h33));
    e = cx(8'h33); e.rw = 1'b1; e.pcs = 2'b10;
    add("jal_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // LOAD with one fetch wait
    add("load_fw", 16'h3005, 1'b0, 1'b0, 1'b0, cf(8'h33));
    add("load_f", 16'h3005, 1'b1, 1'b0, 1'b0, cf(8'h33));
    add("load_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h05));
    add("load_m", 16'h0000, 1'b1, 1'b0, 1'b0, cm(8'h05, 1'b0));
    e = cx(8'h05); e.mw = 1'b1; e.ms = 2'b01;
    add("load_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // MOVS with overflow high in EXEC: not an arithmetic op, no flag
    add("movs_f", 16'h5000, 1'b1, 1'b0, 1'b0, cf(8'h05));
    add("movs_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h00));
    e = cx(8'h00); e.sw = 1'b1;
    add("movs_x", 16'h0000, 1'b0, 1'b0, 1'b1, e);
    // RET
    add("ret_f", 16'h9000, 1'b1, 1'b0, 1'b0, cf(8'h00));
    add("ret_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h00));
    e = cx(8'h00); e.pcs = 2'b11;
    add("ret_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // ASUB
    add("asub_f", 16'h2007, 1'b1, 1'b0, 1'b0, cf(8'h00));
    add("asub_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h07));
    e = cx(8'h07); e.mw = 1'b1; e.sb = 2'b01; e.op = 3'b011;
    add("asub_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // AADD with overflow in EXEC, flag persists through next instruction
    add("ovf_f", 16'h0001, 1'b1, 1'b0, 1'b0, cf(8'h07));
    add("ovf_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h01));
    e = cx(8'h01); e.mw = 1'b1; e.sb = 2'b01; e.op = 3'b010;
    add("ovf_x", 16'h0000, 1'b0, 1'b0, 1'b1, e);
    e = cf(8'h01); e.ovf = 1'b1;
    add("ovf_next_f", 16'h5000, 1'b1, 1'b0, 1'b0, e);
    e = cd(8'h00); e.ovf = 1'b1;
    add("ovf_next_d", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    e = cx(8'h00); e.sw = 1'b1; e.ovf = 1'b1;
    add("ovf_next_x", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    // HALT opcode: terminal, not illegal
    e = cf(8'h00); e.ovf = 1'b1;
    add("halt_f", 16'hF000, 1'b1, 1'b0, 1'b0, e);
    e = cd(8'h00); e.ovf = 1'b1;
    add("halt_d", 16'h0000, 1'b0, 1'b0, 1'b0, e);
    e = '0; e.hlt = 1'b1; e.ovf = 1'b1;
    add("halt_s", 16'h0054, 1'b1, 1'b1, 1'b1, e);
    add("halt_hold", 16'h0054, 1'b1, 1'b1, 1'b1, e);

    // Reset state with every input active
    repeat (2) @(negedge clock);
    #1;
    check("reset_state", '0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].rdata, vecs[i].ready, vecs[i].cz, vecs[i].ov, vecs[i].exp);

    // Reset clears sticky ovf/halted
    do_reset("rst_after_halt");

    // Fetch never acknowledged: four wait cycles then bus_error
    for (int i = 0; i < 4; i++) step("to_wait", 16'h0054, 1'b0, 1'b0, 1'b0, cf(8'h00));
    e = '0; e.hlt = 1'b1; e.berr = 1'b1;
    step("to_halt", 16'h0054, 1'b0, 1'b0, 1'b0, e);
    step("to_halt_hold", 16'h0054, 1'b1, 1'b0, 1'b0, e);

    // Undefined opcode 0xA
    do_reset("rst_before_illegal");
    step("ill_f", 16'hA0C3, 1'b1, 1'b0, 1'b0, cf(8'h00));
    step("ill_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'hC3));
    e = '0; e.hlt = 1'b1; e.ill = 1'b1; e.imm = 8'hC3;
    step("ill_halt", 16'h0000, 1'b1, 1'b0, 1'b0, e);
    step("ill_hold", 16'h0000, 1'b1, 1'b0, 1'b0, e);

    // Reset in the middle of a MEM access
    do_reset("rst_before_mid");
    step("mid_f", 16'h3011, 1'b1, 1'b0, 1'b0, cf(8'h00));
    step("mid_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h11));
    step("mid_m", 16'h0000, 1'b0, 1'b0, 1'b0, cm(8'h11, 1'b0));
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", '0);
    @(negedge clock);
    reset_n = 1'b1;
    step("mid_rel_f", 16'h0054, 1'b0, 1'b0, 1'b0, cf(8'h00));
    step("mid_rel_f2", 16'h0054, 1'b1, 1'b0, 1'b0, cf(8'h00));
    step("mid_rel_d", 16'h0000, 1'b0, 1'b0, 1'b0, cd(8'h54));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
